// File: rtl/upd7800_clkgen.sv
// upd7800_clkgen: two-phase CP1/CP2 generator with edge strobes, reset stretch and HOLD freeze
module upd7800_clkgen #(
    parameter int PHASE_TICKS  = 1,
    parameter int RESET_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CE,
    input  logic HOLD,
    output logic HOLDA,
    output logic CP1,
    output logic CP2,
    output logic CP1_POSEDGE,
    output logic CP1_NEGEDGE,
    output logic CP2_POSEDGE,
    output logic CP2_NEGEDGE,
    output logic RESETB
);
    localparam int TW = $clog2(PHASE_TICKS) + 1;
    localparam logic [TW-1:0] TLAST = TW'(PHASE_TICKS - 1);
    logic [1:0]    r_ph;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_rcnt;
    logic          w_wrap;
    logic          w_hold;
    logic [1:0]    w_nph;
    assign w_wrap = r_tcnt == TLAST;
    assign w_nph  = r_ph + 2'd1;
    // Freeze only at the 3->0 boundary; while frozen ph/tcnt sit there, so a CE with HOLD low resumes cleanly
    assign w_hold = RESETB && HOLD && w_wrap && r_ph == 2'd3;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ph        <= 2'd3;
            r_tcnt      <= '0;
            r_rcnt      <= 8'(RESET_CYCLES);
            CP1         <= 1'b0;
            CP2         <= 1'b0;
            CP1_POSEDGE <= 1'b0;
            CP1_NEGEDGE <= 1'b0;
            CP2_POSEDGE <= 1'b0;
            CP2_NEGEDGE <= 1'b0;
            HOLDA       <= 1'b0;
            RESETB      <= 1'b0;
        end else begin
            CP1_POSEDGE <= 1'b0;
            CP1_NEGEDGE <= 1'b0;
            CP2_POSEDGE <= 1'b0;
            CP2_NEGEDGE <= 1'b0;
            if (CE && w_hold) begin
                HOLDA <= 1'b1;
            end else if (CE) begin
                HOLDA  <= 1'b0;
                r_tcnt <= w_wrap ? '0 : r_tcnt + TW'(1);
                if (w_wrap) begin
                    r_ph        <= w_nph;
                    CP1         <= w_nph == 2'd0;
                    CP2         <= w_nph == 2'd2;
                    CP1_POSEDGE <= w_nph == 2'd0;
                    CP1_NEGEDGE <= w_nph == 2'd1;
                    CP2_POSEDGE <= w_nph == 2'd2;
                    CP2_NEGEDGE <= w_nph == 2'd3;
                    if (w_nph == 2'd0 && !RESETB && r_rcnt != 8'd0)
                        r_rcnt <= r_rcnt - 8'd1;
                    if (w_nph == 2'd3 && r_rcnt == 8'd0)
                        RESETB <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_upd7800_clkgen.sv
// tb_upd7800_clkgen: scoreboard bench; stimulus queues expected strobes, a negedge monitor retires them
module tb_upd7800_clkgen;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    int total = 0;
    int bad = 0;
    logic a_rst, a_ce, a_hold, a_holda, a_cp1, a_cp2, a_p1, a_n1, a_p2, a_n2, a_rb;
    logic b_rst, b_ce, b_hold, b_holda, b_cp1, b_cp2, b_p1, b_n1, b_p2, b_n2, b_rb;
    upd7800_clkgen #(.PHASE_TICKS(1), .RESET_CYCLES(4)) dut_a (
        .CLK(CLK), .RESET(a_rst), .CE(a_ce), .HOLD(a_hold), .HOLDA(a_holda),
        .CP1(a_cp1), .CP2(a_cp2), .CP1_POSEDGE(a_p1), .CP1_NEGEDGE(a_n1),
        .CP2_POSEDGE(a_p2), .CP2_NEGEDGE(a_n2), .RESETB(a_rb)
    );
    upd7800_clkgen #(.PHASE_TICKS(3), .RESET_CYCLES(2)) dut_b (
        .CLK(CLK), .RESET(b_rst), .CE(b_ce), .HOLD(b_hold), .HOLDA(b_holda),
        .CP1(b_cp1), .CP2(b_cp2), .CP1_POSEDGE(b_p1), .CP1_NEGEDGE(b_n1),
        .CP2_POSEDGE(b_p2), .CP2_NEGEDGE(b_n2), .RESETB(b_rb)
    );
    typedef struct {
        int   d;
        int   code;
        int   cyc;
        logic rb;
    } exp_t;
    exp_t q[$];
    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cyc %0d", name, got, want, cyc);
        end
    endtask
    task automatic push(input int d, input int code, input logic rb);
        q.push_back('{d, code, cyc + 1, rb});
    endtask
    task automatic step(input logic ce);
        a_ce = ce;
        @(negedge CLK);
    endtask
    task automatic stretch();
        for (int k = 0; k < 4; k++)
            for (int s = 0; s < 4; s++) begin
                push(1, s, k == 3 && s == 3);
                step(1'b1);
            end
    endtask
    task automatic mon(input int d, input logic [3:0] s, input logic rb, input logic hda, input logic both);
        exp_t e;
        total++;
        if (both) begin
            bad++;
            $display("FAIL overlap dut%0d: CP1 and CP2 both high at cyc %0d", d, cyc);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing dut%0d: strobe code %0d expected at cyc %0d was absent", e.d, e.code, e.cyc);
        end
        if (s != 4'd0) begin
            total++;
            if (q.size() == 0 || q[0].cyc != cyc || q[0].d != d) begin
                bad++;
                $display("FAIL unexpected dut%0d: strobes %b at cyc %0d", d, s, cyc);
            end else begin
                e = q.pop_front();
                if (s != (4'b1 << e.code) || rb != e.rb || hda) begin
                    bad++;
                    $display("FAIL strobe dut%0d cyc %0d: got s=%b rb=%b holda=%b expected s=%b rb=%b holda=0",
                             d, cyc, s, rb, hda, 4'b1 << e.code, e.rb);
                end
            end
        end
    endtask
    always @(negedge CLK) begin
        mon(1, {a_n2, a_p2, a_n1, a_p1}, a_rb, a_holda, a_cp1 & a_cp2);
        mon(3, {b_n2, b_p2, b_n1, b_p1}, b_rb, b_holda, b_cp1 & b_cp2);
    end
    initial begin
        int n;
        a_rst = 1; a_ce = 0; a_hold = 0;
        b_rst = 1; b_ce = 0; b_hold = 0;
        @(negedge CLK);
        step(1'b1);
        chk("reset resetb", a_rb, 0);
        chk("reset cp1", a_cp1, 0);
        chk("reset cp2", a_cp2, 0);
        chk("reset holda", a_holda, 0);
        a_rst = 0;
        stretch();
        chk("t1 resetb high", a_rb, 1);
        step(1'b0);
        // HOLD raised during quarter 1: cycle must finish before freezing
        push(1, 0, 1); step(1'b1);
        push(1, 1, 1); step(1'b1);
        a_hold = 1;
        step(1'b0);
        push(1, 2, 1); step(1'b1);
        push(1, 3, 1); step(1'b1);
        step(1'b1);
        chk("t3 holda set", a_holda, 1);
        repeat (20) step(1'b1);
        chk("t3 holda held", a_holda, 1);
        chk("t3 cp1 frozen", a_cp1, 0);
        chk("t3 cp2 frozen", a_cp2, 0);
        a_hold = 0;
        step(1'b0);
        chk("t3 holda no ce", a_holda, 1);
        push(1, 0, 1); step(1'b1);
        chk("t3 holda release", a_holda, 0);
        chk("t3 cp1 release", a_cp1, 1);
        for (int s = 1; s < 4; s++) begin
            push(1, s, 1);
            step(1'b1);
        end
        a_hold = 1;
        step(1'b0);
        a_hold = 0;
        push(1, 0, 1); step(1'b1);
        chk("t3 pulse ignored", a_holda, 0);
        for (int s = 1; s < 4; s++) begin
            push(1, s, 1);
            step(1'b1);
        end
        step(1'b0);
        a_rst = 1; a_hold = 1;
        step(1'b1);
        a_rst = 0;
        stretch();
        chk("t4 holda in stretch", a_holda, 0);
        step(1'b1);
        chk("t4 holda after", a_holda, 1);
        a_rst = 1;
        step(1'b1);
        chk("t6 holda", a_holda, 0);
        chk("t6 resetb", a_rb, 0);
        chk("t6 cp1", a_cp1, 0);
        chk("t6 cp2", a_cp2, 0);
        a_rst = 0; a_hold = 0;
        for (int s = 0; s < 7; s++) begin
            push(1, s % 4, 0);
            step(1'b1);
        end
        chk("t5 cp2 before", a_cp2, 1);
        a_rst = 1;
        step(1'b1);
        chk("t5 cp2 dropped", a_cp2, 0);
        chk("t5 resetb", a_rb, 0);
        a_rst = 0;
        stretch();
        step(1'b0);
        // PHASE_TICKS=3 with CE every other CLK: one strobe per 3 CEs, i.e. 6 CLKs
        @(negedge CLK);
        b_rst = 0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (i % 2 == 0) begin
                n++;
                if (n % 3 == 0) push(3, (n / 3 - 1) % 4, n / 3 >= 8);
            end
            b_ce = i % 2 == 0;
            @(negedge CLK);
        end
        chk("t2 resetb", b_rb, 1);
        b_ce = 0;
        repeat (3) @(negedge CLK);
        chk("queue drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
